// File: rtl/adam_fab_txn_router.sv
// rtl/adam_fab_txn_router.sv - single-master in-order request/response router
// Requests steer combinationally to the decoded target; responses return from the target of the in-flight burst.
module adam_fab_txn_router #(
  parameter int ADDR_WIDTH = 32,
  parameter int NO_SLVS    = 4,
  parameter int MAX_TRANS  = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NO_SLVS*ADDR_WIDTH-1:0] map_start,
  input  logic [NO_SLVS*ADDR_WIDTH-1:0] map_end,
  input  logic                          mst_req_valid,
  output logic                          mst_req_ready,
  input  logic [ADDR_WIDTH-1:0]         mst_req_addr,
  output logic [NO_SLVS-1:0]            slv_req_valid,
  input  logic [NO_SLVS-1:0]            slv_req_ready,
  input  logic [NO_SLVS-1:0]            slv_rsp_valid,
  output logic [NO_SLVS-1:0]            slv_rsp_ready,
  output logic                          mst_rsp_valid,
  input  logic                          mst_rsp_ready,
  output logic                          mst_rsp_err
);

  localparam int CW = $clog2(NO_SLVS + 1);
  localparam int NW = $clog2(MAX_TRANS + 1);
  localparam logic [CW-1:0] ERR_IDX = CW'(NO_SLVS);
  localparam logic [NW-1:0] CNT_MAX = NW'(MAX_TRANS);

  typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cur_q, cur_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] tgt;
  logic          pass, accept, rsp_hs;

  // Descending scan so the lowest matching region wins; start >= end never matches.
  always_comb begin
    tgt = ERR_IDX;
    for (int i = NO_SLVS - 1; i >= 0; i--) begin
      if (map_start[i*ADDR_WIDTH +: ADDR_WIDTH] <= mst_req_addr &&
          mst_req_addr < map_end[i*ADDR_WIDTH +: ADDR_WIDTH])
        tgt = CW'(i);
    end
  end

  assign pass = (state_q == IDLE) || (state_q == BUSY && tgt == cur_q);

  always_comb begin
    slv_req_valid = '0;
    mst_req_ready = 1'b0;
    if (!rst && pass) begin
      if (tgt == ERR_IDX) begin
        mst_req_ready = 1'b1;
      end else begin
        for (int i = 0; i < NO_SLVS; i++) begin
          if (tgt == CW'(i)) begin
            slv_req_valid[i] = mst_req_valid;
            mst_req_ready    = slv_req_ready[i];
          end
        end
      end
    end
  end

  // Slave responses are held off entirely while nothing is outstanding.
  always_comb begin
    slv_rsp_ready = '0;
    mst_rsp_valid = 1'b0;
    mst_rsp_err   = 1'b0;
    if (!rst && state_q != IDLE) begin
      if (cur_q == ERR_IDX) begin
        mst_rsp_valid = 1'b1;
        mst_rsp_err   = 1'b1;
      end else begin
        for (int i = 0; i < NO_SLVS; i++) begin
          if (cur_q == CW'(i)) begin
            mst_rsp_valid    = slv_rsp_valid[i];
            slv_rsp_ready[i] = mst_rsp_ready;
          end
        end
      end
    end
  end

  assign accept = mst_req_valid & mst_req_ready;
  assign rsp_hs = mst_rsp_valid & mst_rsp_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !rsp_hs)
      cnt_d = cnt_q + NW'(1);
    else if (!accept && rsp_hs)
      cnt_d = cnt_q - NW'(1);
    cur_d = accept ? tgt : cur_q;
    if (cnt_d == '0)
      state_d = IDLE;
    else if (cnt_d == CNT_MAX)
      state_d = FULL;
    else
      state_d = BUSY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
    end
  end

endmodule

// File: tb/tb_adam_fab_txn_router.sv
// tb/tb_adam_fab_txn_router.sv - directed bench with response-order scoreboard
// Accepted requests queue their expected target; each response handshake pops and checks it.
module tb_adam_fab_txn_router;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] map_start, map_end;
  logic         mst_req_valid, mst_req_ready;
  logic [31:0]  mst_req_addr;
  logic [3:0]   slv_req_valid, slv_req_ready, slv_rsp_valid, slv_rsp_ready;
  logic         mst_rsp_valid, mst_rsp_ready, mst_rsp_err;

  int total = 0;
  int bad   = 0;
  int sb[$];
  logic [31:0] addrs [6];

  adam_fab_txn_router #(.ADDR_WIDTH(32), .NO_SLVS(4), .MAX_TRANS(7)) dut (
    .clk(clk), .rst(rst), .map_start(map_start), .map_end(map_end),
    .mst_req_valid(mst_req_valid), .mst_req_ready(mst_req_ready), .mst_req_addr(mst_req_addr),
    .slv_req_valid(slv_req_valid), .slv_req_ready(slv_req_ready),
    .slv_rsp_valid(slv_rsp_valid), .slv_rsp_ready(slv_rsp_ready),
    .mst_rsp_valid(mst_rsp_valid), .mst_rsp_ready(mst_rsp_ready), .mst_rsp_err(mst_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_tgt(input logic [31:0] a);
    if (a < 32'h8000) return 0;
    if (a >= 32'h8000 && a < 32'h8400) return 1;
    if (a >= 32'h10000 && a < 32'h18000) return 2;
    if (a >= 32'h1000000 && a < 32'hFFFFFFFF) return 3;
    return 4;
  endfunction

  function automatic logic [3:0] onehot(input int t);
    return (t < 4) ? 4'(1 << t) : 4'b0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mst_rsp_valid && mst_rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          int e;
          e = sb.pop_front();
          chk("sb_rsp_err", {31'd0, mst_rsp_err}, (e == 4) ? 32'd1 : 32'd0);
          chk("sb_rsp_src", {28'd0, slv_rsp_ready}, {28'd0, onehot(e)});
        end
      end
      if (mst_req_valid && mst_req_ready)
        sb.push_back(model_tgt(mst_req_addr));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    map_start = {32'h0100_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_0000};
    map_end   = {32'hFFFF_FFFF, 32'h0001_8000, 32'h0000_8400, 32'h0000_8000};
    mst_req_valid = 1'b1; mst_req_addr = 32'h8004; slv_req_ready = 4'hF;
    slv_rsp_valid = 4'hF; mst_rsp_ready = 1'b1;
    #2;
    chk("rst_req_ready", {31'd0, mst_req_ready}, 32'd0);
    chk("rst_slv_req_valid", {28'd0, slv_req_valid}, 32'd0);
    chk("rst_slv_rsp_ready", {28'd0, slv_rsp_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, mst_rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, mst_rsp_err}, 32'd0);
    mst_req_valid = 1'b0; slv_rsp_valid = 4'h0; mst_rsp_ready = 1'b0; slv_req_ready = 4'h0;
    tick(); tick();
    rst = 1'b0;

    // 1: mapped request to target 1
    mst_req_valid = 1'b1; mst_req_addr = 32'h8004; slv_req_ready = 4'b0010;
    #1 chk("t1_slv_req_valid", {28'd0, slv_req_valid}, 32'b0010);
    chk("t1_req_ready", {31'd0, mst_req_ready}, 32'd1);
    tick();
    mst_req_valid = 1'b0; mst_rsp_ready = 1'b1;
    #1 chk("t1_cnt", {29'd0, dut.cnt_q}, 32'd1);
    chk("t1_cur_rsp_ready", {28'd0, slv_rsp_ready}, 32'b0010);
    chk("t1_rsp_wait", {31'd0, mst_rsp_valid}, 32'd0);
    slv_rsp_valid = 4'b0010;
    #1 chk("t1_rsp_valid", {31'd0, mst_rsp_valid}, 32'd1);
    tick();
    slv_rsp_valid = 4'b0000;
    #1 chk("t1_cnt_drain", {29'd0, dut.cnt_q}, 32'd0);

    // 2: unmapped request gets an internal error response
    mst_req_valid = 1'b1; mst_req_addr = 32'h9000; mst_rsp_ready = 1'b0; slv_req_ready = 4'hF;
    #1 chk("t2_req_ready", {31'd0, mst_req_ready}, 32'd1);
    chk("t2_no_slv_valid", {28'd0, slv_req_valid}, 32'd0);
    chk("t2_no_rsp_yet", {31'd0, mst_rsp_valid}, 32'd0);
    tick();
    mst_req_valid = 1'b0;
    #1 chk("t2_err_valid", {31'd0, mst_rsp_valid}, 32'd1);
    chk("t2_err_flag", {31'd0, mst_rsp_err}, 32'd1);
    mst_rsp_ready = 1'b1;
    tick();
    #1 chk("t2_cnt", {29'd0, dut.cnt_q}, 32'd0);
    chk("t2_rsp_gone", {31'd0, mst_rsp_valid}, 32'd0);

    // 3: fill to MAX_TRANS, full blocks even with a response present
    mst_rsp_ready = 1'b0; slv_req_ready = 4'b0100;
    mst_req_valid = 1'b1; mst_req_addr = 32'h10000;
    for (int i = 0; i < 7; i++) begin
      #1 chk($sformatf("t3_acc%0d", i), {31'd0, mst_req_ready}, 32'd1);
      tick();
    end
    #1 chk("t3_full_ready", {31'd0, mst_req_ready}, 32'd0);
    chk("t3_full_valid", {28'd0, slv_req_valid}, 32'd0);
    chk("t3_cnt7", {29'd0, dut.cnt_q}, 32'd7);
    tick();
    slv_rsp_valid = 4'b0100; mst_rsp_ready = 1'b1;
    #1 chk("t3_full_with_rsp", {31'd0, mst_req_ready}, 32'd0);
    tick();
    slv_rsp_valid = 4'b0000; mst_rsp_ready = 1'b0;
    #1 chk("t3_8th_ready", {31'd0, mst_req_ready}, 32'd1);
    tick();
    mst_req_valid = 1'b0;
    #1 chk("t3_cnt_back7", {29'd0, dut.cnt_q}, 32'd7);
    slv_rsp_valid = 4'b0100; mst_rsp_ready = 1'b1;
    repeat (7) tick();
    slv_rsp_valid = 4'b0000;
    #1 chk("t3_drained", {29'd0, dut.cnt_q}, 32'd0);

    // 4: target switch waits for drain
    mst_rsp_ready = 1'b0; slv_req_ready = 4'b1001;
    mst_req_valid = 1'b1; mst_req_addr = 32'h100;
    tick(); tick();
    mst_req_addr = 32'h0100_0000;
    #1 chk("t4_stall_ready", {31'd0, mst_req_ready}, 32'd0);
    chk("t4_stall_valid", {28'd0, slv_req_valid}, 32'd0);
    slv_rsp_valid = 4'b0001; mst_rsp_ready = 1'b1;
    tick();
    #1 chk("t4_stall_cnt1", {31'd0, mst_req_ready}, 32'd0);
    tick();
    slv_rsp_valid = 4'b0000;
    #1 chk("t4_switch_valid", {28'd0, slv_req_valid}, 32'b1000);
    chk("t4_switch_ready", {31'd0, mst_req_ready}, 32'd1);
    tick();
    mst_req_valid = 1'b0;
    #1 chk("t4_cnt1", {29'd0, dut.cnt_q}, 32'd1);

    // 5: accept and response in the same cycle at cnt==1
    mst_req_valid = 1'b1; mst_req_addr = 32'h0200_0000; slv_rsp_valid = 4'b1000;
    #1 chk("t5_acc", {31'd0, mst_req_ready}, 32'd1);
    chk("t5_rsp", {31'd0, mst_rsp_valid}, 32'd1);
    tick();
    mst_req_valid = 1'b0; slv_rsp_valid = 4'b0000;
    #1 chk("t5_cnt_same", {29'd0, dut.cnt_q}, 32'd1);
    chk("t5_cur", {28'd0, slv_rsp_ready}, 32'b1000);
    slv_rsp_valid = 4'b1000;
    tick();
    slv_rsp_valid = 4'b0000;

    // decode boundaries
    addrs[0] = 32'h0000_7FFF; addrs[1] = 32'h0000_8400; addrs[2] = 32'h0001_7FFF;
    addrs[3] = 32'h0001_8000; addrs[4] = 32'hFFFF_FFFE; addrs[5] = 32'hFFFF_FFFF;
    slv_req_ready = 4'hF; slv_rsp_valid = 4'hF; mst_rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mst_req_valid = 1'b1; mst_req_addr = addrs[i];
      #1 chk($sformatf("bnd_valid_%0h", addrs[i]), {28'd0, slv_req_valid}, {28'd0, onehot(model_tgt(addrs[i]))});
      tick();
      mst_req_valid = 1'b0;
      tick();
    end
    slv_rsp_valid = 4'h0; mst_rsp_ready = 1'b0;
    #1 chk("bnd_cnt", {29'd0, dut.cnt_q}, 32'd0);

    // 6: asynchronous reset with three outstanding
    slv_req_ready = 4'b0100; mst_req_valid = 1'b1; mst_req_addr = 32'h10000;
    tick(); tick(); tick();
    #1 chk("t6_cnt3", {29'd0, dut.cnt_q}, 32'd3);
    mst_rsp_ready = 1'b1;
    #1 chk("t6_pre_rsp_ready", {28'd0, slv_rsp_ready}, 32'b0100);
    rst = 1'b1;
    sb.delete();
    #1 chk("t6_rst_req_ready", {31'd0, mst_req_ready}, 32'd0);
    chk("t6_rst_slv_valid", {28'd0, slv_req_valid}, 32'd0);
    chk("t6_rst_rsp_ready", {28'd0, slv_rsp_ready}, 32'd0);
    chk("t6_rst_cnt", {29'd0, dut.cnt_q}, 32'd0);
    tick();
    rst = 1'b0; mst_req_valid = 1'b0; slv_rsp_valid = 4'b0100;
    #1 chk("t6_stray_fwd", {31'd0, mst_rsp_valid}, 32'd0);
    chk("t6_stray_ready", {28'd0, slv_rsp_ready}, 32'd0);
    tick();
    slv_rsp_valid = 4'b0000;
    #1 chk("t6_cnt_after", {29'd0, dut.cnt_q}, 32'd0);
    chk("sb_empty_end", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
